// File: rtl/issue_age_select.sv
// issue_age_select: oldest-first select for one issue queue.
// An age matrix tracks relative allocation order between occupied slots.
// Each cycle the logic grants the oldest eligible slot when the FU port is
// ready, and it registers the index of the issued slot for the next stage.
// Optional build macro ISSUE_SELECT_PERF_EN adds saturating issue and stall
// counters as extra outputs.
//
// Handshake: a slot presents "valid" when it is occupied, requesting, not
// killed, and no flush is active. io_fu_ready is the FU's "ready". A uop
// transfers only in a cycle where both are high and that slot is the oldest
// valid one. io_grant marks that transfer, and no transfer occurs without it.
module issue_age_select #(
  parameter int NUM_SLOTS = 8,
  parameter int IDX_W     = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 io_alloc_valid,
  input  logic [IDX_W-1:0]     io_alloc_idx,
  input  logic [NUM_SLOTS-1:0] io_request,
  input  logic [NUM_SLOTS-1:0] io_kill,
  input  logic                 io_flush,
  input  logic                 io_fu_ready,
  output logic [NUM_SLOTS-1:0] io_grant,
  output logic [NUM_SLOTS-1:0] io_occupied,
  output logic                 io_iss_valid,
  output logic [IDX_W-1:0]     io_iss_idx,
  output logic                 io_alloc_err
`ifdef ISSUE_SELECT_PERF_EN
  ,
  output logic [15:0]          io_perf_issued,
  output logic [15:0]          io_perf_stall
`endif
);

  // older_q[i][j] = 1 means slot i was allocated before slot j
  logic [NUM_SLOTS-1:0][NUM_SLOTS-1:0] older_q, older_d;
  logic [NUM_SLOTS-1:0] occ_q, occ_d;
  logic [NUM_SLOTS-1:0] elig, blocked, grant, occ_free, alloc_hot;
  logic [IDX_W-1:0]     grant_idx;
  logic                 iss_valid_q;
  logic [IDX_W-1:0]     iss_idx_q;
  logic                 err_q, err_d;

  // Slots that may compete this cycle; a flush silences everyone
  always_comb begin
    elig = occ_q & io_request & ~io_kill & {NUM_SLOTS{~io_flush}};
  end

  // A slot is blocked if any other eligible slot is older than it.
  // Age entries of non-eligible slots are masked by elig.
  always_comb begin
    blocked = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      for (int j = 0; j < NUM_SLOTS; j++) begin
        if (j != i) begin
          blocked[i] = blocked[i] | (elig[j] & older_q[j][i]);
        end
      end
    end
  end

  // Zero-latency oldest-first grant
  always_comb begin
    grant = {NUM_SLOTS{io_fu_ready}} & elig & ~blocked;
  end

  assign io_grant = grant;

  // Binary encode of the (at most one-hot) grant vector
  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (grant[i]) begin
        grant_idx = IDX_W'(i);
      end
    end
  end

  // Occupancy after grant/kill frees, before allocation. A flush suppresses allocation.
  always_comb begin
    occ_free  = occ_q & ~grant & ~io_kill;
    alloc_hot = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      alloc_hot[i] = io_alloc_valid & ~io_flush & (io_alloc_idx == IDX_W'(i));
    end
    occ_d = io_flush ? '0 : (occ_free | alloc_hot);
    err_d = err_q | (|(alloc_hot & occ_free));
  end

  // Allocated slot becomes youngest: every surviving occupant is older than it
  always_comb begin
    older_d = older_q;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (alloc_hot[k]) begin
        for (int j = 0; j < NUM_SLOTS; j++) begin
          older_d[j][k] = (j != k) ? occ_free[j] : 1'b0;
        end
        older_d[k] = '0;
      end
    end
  end

  // State and issue register update
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ_q       <= '0;
      older_q     <= '0;
      iss_valid_q <= 1'b0;
      iss_idx_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      occ_q       <= occ_d;
      older_q     <= older_d;
      iss_valid_q <= |grant;
      if (|grant) begin
        iss_idx_q <= grant_idx;
      end
      err_q       <= err_d;
    end
  end

  assign io_occupied  = occ_q;
  assign io_iss_valid = iss_valid_q;
  assign io_iss_idx   = iss_idx_q;
  assign io_alloc_err = err_q;

`ifdef ISSUE_SELECT_PERF_EN
  logic [15:0] perf_issued_q, perf_stall_q;

  // Saturating issue/stall counters, cleared by flush
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_issued_q <= '0;
      perf_stall_q  <= '0;
    end else if (io_flush) begin
      perf_issued_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      if ((|grant) && (perf_issued_q != 16'hFFFF)) begin
        perf_issued_q <= perf_issued_q + 16'd1;
      end
      if ((|elig) && !io_fu_ready && (perf_stall_q != 16'hFFFF)) begin
        perf_stall_q <= perf_stall_q + 16'd1;
      end
    end
  end

  assign io_perf_issued = perf_issued_q;
  assign io_perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_issue_age_select.sv
// tb_issue_age_select: directed, table-driven bench for issue_age_select.
// Each table row is one clock cycle. The bench drives the row's inputs and
// checks the combinational grant. After the clock edge it checks the
// registered outputs.
module tb_issue_age_select;

  localparam int N  = 8;
  localparam int IW = 3;

  typedef struct {
    logic          av;
    logic [IW-1:0] ai;
    logic [N-1:0]  rq;
    logic [N-1:0]  kl;
    logic          fl;
    logic          fu;
    logic [N-1:0]  eg;   // expected grant (same cycle)
    logic [N-1:0]  eo;   // expected occupied after edge
    logic          ev;   // expected iss_valid after edge
    logic [IW-1:0] ei;   // expected iss_idx after edge
    logic          ee;   // expected alloc_err after edge
  } vec_t;

  logic          clk;
  logic          rst_n;
  logic          alloc_valid;
  logic [IW-1:0] alloc_idx;
  logic [N-1:0]  request;
  logic [N-1:0]  kill;
  logic          flush;
  logic          fu_ready;
  logic [N-1:0]  grant;
  logic [N-1:0]  occupied;
  logic          iss_valid;
  logic [IW-1:0] iss_idx;
  logic          alloc_err;
`ifdef ISSUE_SELECT_PERF_EN
  logic [15:0]   perf_issued;
  logic [15:0]   perf_stall;
`endif

  int tests_run;
  int tests_failed;
  vec_t vecs[$];

  issue_age_select #(.NUM_SLOTS(N), .IDX_W(IW)) dut (
    .clk            (clk),
    .reset          (rst_n),
    .io_alloc_valid (alloc_valid),
    .io_alloc_idx   (alloc_idx),
    .io_request     (request),
    .io_kill        (kill),
    .io_flush       (flush),
    .io_fu_ready    (fu_ready),
    .io_grant       (grant),
    .io_occupied    (occupied),
    .io_iss_valid   (iss_valid),
    .io_iss_idx     (iss_idx),
    .io_alloc_err   (alloc_err)
`ifdef ISSUE_SELECT_PERF_EN
    ,
    .io_perf_issued (perf_issued),
    .io_perf_stall  (perf_stall)
`endif
  );

  // Clock generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic av, input logic [IW-1:0] ai,
                              input logic [N-1:0] rq, input logic [N-1:0] kl,
                              input logic fl, input logic fu,
                              input logic [N-1:0] eg, input logic [N-1:0] eo,
                              input logic ev, input logic [IW-1:0] ei,
                              input logic ee);
    vec_t v;
    v.av = av; v.ai = ai; v.rq = rq; v.kl = kl; v.fl = fl; v.fu = fu;
    v.eg = eg; v.eo = eo; v.ev = ev; v.ei = ei; v.ee = ee;
    return v;
  endfunction

  task automatic drive_idle();
    alloc_valid = 1'b0;
    alloc_idx   = '0;
    request     = '0;
    kill        = '0;
    flush       = 1'b0;
    fu_ready    = 1'b0;
  endtask

  task automatic apply_vec(input vec_t v, input string tag);
    @(negedge clk);
    alloc_valid = v.av;
    alloc_idx   = v.ai;
    request     = v.rq;
    kill        = v.kl;
    flush       = v.fl;
    fu_ready    = v.fu;
    #1;
    check({tag, " grant"}, 32'(grant), 32'(v.eg));
    @(posedge clk);
    #1;
    check({tag, " occupied"},  32'(occupied),  32'(v.eo));
    check({tag, " iss_valid"}, 32'(iss_valid), 32'(v.ev));
    check({tag, " iss_idx"},   32'(iss_idx),   32'(v.ei));
    check({tag, " alloc_err"}, 32'(alloc_err), 32'(v.ee));
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    drive_idle();

    //        av  ai  rq     kl     fl fu  eg     eo     ev ei ee
    // Age order: 6, 1, 3
    vecs.push_back(mk(1, 6, 8'h00, 8'h00, 0, 0, 8'h00, 8'h40, 0, 0, 0));
    vecs.push_back(mk(1, 1, 8'h00, 8'h00, 0, 0, 8'h00, 8'h42, 0, 0, 0));
    vecs.push_back(mk(1, 3, 8'h00, 8'h00, 0, 0, 8'h00, 8'h4A, 0, 0, 0));
    vecs.push_back(mk(0, 0, 8'h4A, 8'h00, 0, 1, 8'h40, 8'h0A, 1, 6, 0));
    vecs.push_back(mk(0, 0, 8'h0A, 8'h00, 0, 1, 8'h02, 8'h08, 1, 1, 0));
    vecs.push_back(mk(0, 0, 8'h08, 8'h00, 0, 1, 8'h08, 8'h00, 1, 3, 0));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 0, 1, 8'h00, 8'h00, 0, 3, 0));
    // Backpressure: slots 0 then 4, fu not ready for three cycles
    vecs.push_back(mk(1, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h01, 0, 3, 0));
    vecs.push_back(mk(1, 4, 8'h00, 8'h00, 0, 0, 8'h00, 8'h11, 0, 3, 0));
    vecs.push_back(mk(0, 0, 8'h11, 8'h00, 0, 0, 8'h00, 8'h11, 0, 3, 0));
    vecs.push_back(mk(0, 0, 8'h11, 8'h00, 0, 0, 8'h00, 8'h11, 0, 3, 0));
    vecs.push_back(mk(0, 0, 8'h11, 8'h00, 0, 0, 8'h00, 8'h11, 0, 3, 0));
    vecs.push_back(mk(0, 0, 8'h11, 8'h00, 0, 1, 8'h01, 8'h10, 1, 0, 0));
    vecs.push_back(mk(0, 0, 8'h10, 8'h00, 0, 1, 8'h10, 8'h00, 1, 4, 0));
    // Kill: older slot 2 killed, slot 7 wins
    vecs.push_back(mk(1, 2, 8'h00, 8'h00, 0, 0, 8'h00, 8'h04, 0, 4, 0));
    vecs.push_back(mk(1, 7, 8'h00, 8'h00, 0, 0, 8'h00, 8'h84, 0, 4, 0));
    vecs.push_back(mk(0, 0, 8'h84, 8'h04, 0, 1, 8'h80, 8'h00, 1, 7, 0));
    // Realloc into a slot granted the same cycle
    vecs.push_back(mk(1, 5, 8'h00, 8'h00, 0, 0, 8'h00, 8'h20, 0, 7, 0));
    vecs.push_back(mk(1, 3, 8'h00, 8'h00, 0, 0, 8'h00, 8'h28, 0, 7, 0));
    vecs.push_back(mk(1, 3, 8'h08, 8'h00, 0, 1, 8'h08, 8'h28, 1, 3, 0));
    // Slot 3 is now younger than 5
    vecs.push_back(mk(0, 0, 8'h28, 8'h00, 0, 1, 8'h20, 8'h08, 1, 5, 0));
    vecs.push_back(mk(1, 5, 8'h00, 8'h00, 0, 0, 8'h00, 8'h28, 0, 5, 0));
    // Alloc into occupied, non-freed slot 5: sticky error, 5 becomes youngest
    vecs.push_back(mk(1, 5, 8'h00, 8'h00, 0, 0, 8'h00, 8'h28, 0, 5, 1));
    vecs.push_back(mk(0, 0, 8'h28, 8'h00, 0, 1, 8'h08, 8'h20, 1, 3, 1));
    // Flush with four slots occupied and an allocation attempt
    vecs.push_back(mk(1, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h21, 0, 3, 1));
    vecs.push_back(mk(1, 1, 8'h00, 8'h00, 0, 0, 8'h00, 8'h23, 0, 3, 1));
    vecs.push_back(mk(1, 2, 8'h00, 8'h00, 0, 0, 8'h00, 8'h27, 0, 3, 1));
    vecs.push_back(mk(1, 6, 8'h27, 8'h00, 1, 1, 8'h00, 8'h00, 0, 3, 1));
    // Queue usable after flush
    vecs.push_back(mk(1, 4, 8'h00, 8'h00, 0, 0, 8'h00, 8'h10, 0, 3, 1));
    vecs.push_back(mk(0, 0, 8'h10, 8'h00, 0, 1, 8'h10, 8'h00, 1, 4, 1));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 0, 1, 8'h00, 8'h00, 0, 4, 1));
    // Occupy slots 2 and 5 before the mid-run reset
    vecs.push_back(mk(1, 2, 8'h00, 8'h00, 0, 0, 8'h00, 8'h04, 0, 4, 1));
    vecs.push_back(mk(1, 5, 8'h00, 8'h00, 0, 0, 8'h00, 8'h24, 0, 4, 1));

    // Power-on reset state
    repeat (2) @(posedge clk);
    #1;
    check("por occupied",  32'(occupied),  32'h0);
    check("por iss_valid", 32'(iss_valid), 32'h0);
    check("por iss_idx",   32'(iss_idx),   32'h0);
    check("por alloc_err", 32'(alloc_err), 32'h0);
    check("por grant",     32'(grant),     32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      apply_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Mid-run asynchronous reset with slots 2 and 5 occupied and requesting
    @(negedge clk);
    drive_idle();
    request  = 8'h24;
    fu_ready = 1'b1;
    #1;
    check("pre_rst grant", 32'(grant), 32'h04);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst occupied",  32'(occupied),  32'h0);
    check("rst iss_valid", 32'(iss_valid), 32'h0);
    check("rst iss_idx",   32'(iss_idx),   32'h0);
    check("rst alloc_err", 32'(alloc_err), 32'h0);
    check("rst grant",     32'(grant),     32'h0);
    @(negedge clk);
    drive_idle();
    rst_n = 1'b1;
    apply_vec(mk(1, 1, 8'h00, 8'h00, 0, 0, 8'h00, 8'h02, 0, 0, 0), "post_rst");

    drive_idle();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global time guard
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected finish before 100000");
    $fatal(1);
  end

endmodule

// File: doc/issue_age_select.md
Name: issue_age_select

Overview:
- Oldest-first select controller for one issue queue of NUM_SLOTS issue slots.
- Tracks slot occupancy and relative allocation age with an age matrix.
- Picks the single oldest requesting slot when the functional unit is ready, and drives the per-slot grant lines.
- Registers the issued slot index toward the register-read/FU stage.
- Sits between dispatch (slot allocation), the issue slots (request/grant/kill) and one FU port.

Parameters:
- NUM_SLOTS, 8, number of issue slots arbitrated; legal range 2..16.
- IDX_W, 3, slot index width; must equal $clog2(NUM_SLOTS).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- io_alloc_valid  in  1  dispatch writes a uop into slot io_alloc_idx this cycle.
- io_alloc_idx  in  IDX_W  slot being allocated.
- io_request  in  NUM_SLOTS  per-slot request (slot operands ready).
- io_kill  in  NUM_SLOTS  per-slot kill (branch mispredict squash).
- io_flush  in  1  pipeline flush; empties the whole queue.
- io_fu_ready  in  1  FU port can accept a uop this cycle.
- io_grant  out  NUM_SLOTS  one-hot or zero grant to the slots; combinational from state and inputs.
- io_occupied  out  NUM_SLOTS  registered occupancy vector.
- io_iss_valid  out  1  registered: a uop was issued last cycle.
- io_iss_idx  out  IDX_W  registered index of the slot issued last cycle.
- io_alloc_err  out  1  sticky: allocation was attempted into an occupied, non-freed slot.

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - occupied, age matrix, io_iss_valid, io_alloc_err all to 0.
  - io_iss_idx to 0.
  - io_grant therefore 0.
- Age matrix: older[i][j]=1 means slot i was allocated before slot j. The diagonal is always 0.
- Eligibility: elig[i] = occupied[i] & io_request[i] & ~io_kill[i] & ~io_flush.
- Grant rule: io_grant[i] = io_fu_ready & elig[i] & no j with elig[j] & older[j][i].
  - At most one bit is set.
  - Zero-latency select: the same cycle as the request.
- Issue register (next edge):
  - io_iss_valid <= |io_grant.
  - io_iss_idx <= encode(io_grant); held when no grant.
  - One-cycle latency from grant to io_iss_valid.
- Freeing: a granted slot has occupied cleared at the next edge. A killed slot likewise.
- Allocation of slot k at the edge:
  - occupied[k] <= 1.
  - older[j][k] <= occupied_next_before_alloc[j] for all j≠k, i.e. all surviving occupants become older than k.
  - older[k][*] <= 0, so k is the youngest.
- Same-cycle events, priority order:
  - flush > alloc > grant/kill free.
  - Alloc into a slot being granted or killed the same cycle: legal. The slot ends occupied and youngest. The grant still issues the old uop (io_iss_idx=k next cycle).
  - Alloc into a slot that is occupied and neither granted nor killed: the allocation still overwrites age state (k becomes youngest), and io_alloc_err <= 1 (sticky until reset).
- Flush:
  - occupied <= 0 and io_iss_valid <= 0 at the edge.
  - io_grant is forced to 0 in the flush cycle.
  - io_alloc_valid is ignored.
  - The age matrix need not be cleared; it is don't-care for unoccupied slots.
- io_fu_ready=0: io_grant=0, no state change except alloc/kill/flush; requests stay pending.
- Empty queue: io_grant=0, io_iss_valid falls to 0 the next cycle.
- Full queue: no internal stall; dispatch must only allocate freed slots (io_alloc_err flags violations).
- Entries for unoccupied slots in older[][] are ignored by the grant logic.

Optional Feature:
- Macro: ISSUE_SELECT_PERF_EN.
- When defined, the block adds two outputs:
  - io_perf_issued [15:0]: increments on each cycle with |io_grant.
  - io_perf_stall [15:0]: increments on each cycle with |elig & ~io_fu_ready.
  - Both counters saturate at 16'hFFFF, reset to 0, and clear on io_flush.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then idle: reset low mid-run with slots 2 and 5 occupied → io_occupied=0, io_iss_valid=0, io_alloc_err=0 immediately; io_grant=0.
- Age order: alloc slots 6, 1, 3 on consecutive cycles, then request all three with fu_ready=1 → grants 6, 1, 3 on successive cycles; io_iss_idx=6, 1, 3 one cycle later each.
- Backpressure: slots 0 and 4 requesting, fu_ready=0 for 3 cycles → io_grant=0 and io_iss_valid=0 throughout. fu_ready=1 → oldest granted first.
- Kill: slots 2 (older) and 7 requesting with io_kill[2]=1 in the same cycle → io_grant=8'h80; slot 2 unoccupied next cycle.
- Realloc on free: slot 3 granted while io_alloc_valid=1, idx=3, and slot 5 occupied → io_iss_idx=3 next cycle, slot 3 occupied and younger than 5, io_alloc_err=0. Then alloc idx=5 with no free → io_alloc_err=1.
- Flush: 4 slots occupied, io_flush=1 with io_alloc_valid=1 → io_grant=0 that cycle; io_occupied=0 and io_iss_valid=0 next cycle.
